// File: rtl/clock_div_pkg.sv
// Shared types and helpers for the runtime-programmable clock divider.
package clock_div_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLIED = 2'd2
    } state_t;

    // Midpoint of the counter range; CLK_OUT is the counter MSB, high at and above it.
    function automatic int half_of(input int width);
        return 1 << (width - 1);
    endfunction

    // A setting is usable only if the counter crosses the MSB boundary every period.
    function automatic logic cfg_valid(input int lower, input int upper, input int width);
        return (lower < half_of(width)) && (half_of(width) <= upper);
    endfunction

endpackage

// File: rtl/clock_div_core.sv
// Divide counter: free-running increment, wrap-and-reload at the upper bound, HOLD freeze.
module clock_div_core
    import clock_div_pkg::*;
#(
    parameter int width      = 4,
    parameter int init_upper = 9
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             HOLD,
    input  logic             load_lower,
    input  logic [width-1:0] pend_lower,
    input  logic [width-1:0] act_lower,
    input  logic [width-1:0] act_upper,
    output logic [width-1:0] cntr,
    output logic             wrap,
    output logic             clk_out,
    output logic             preedge
);

    localparam int               HALF     = half_of(width);
    localparam logic [width-1:0] PRE_EDGE = width'(HALF - 1);

    // A held counter never wraps, so a pending setting cannot slip in during HOLD.
    assign wrap    = !HOLD && (cntr == act_upper);
    assign clk_out = cntr[width-1];
    assign preedge = !HOLD && (cntr == PRE_EDGE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cntr <= width'(init_upper);
        end else if (!HOLD) begin
            if (cntr == act_upper)
                cntr <= load_lower ? pend_lower : act_lower;
            else
                cntr <= cntr + 1'b1;
        end
    end

endmodule

// File: rtl/clock_div_ctrl.sv
// Clock-divider controller: config handshake, pending registers and period-boundary apply.
module clock_div_ctrl
    import clock_div_pkg::*;
#(
    parameter int width      = 4,
    parameter int init_lower = 7,
    parameter int init_upper = 9
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CFG_EN,
    input  logic [width-1:0] CFG_LOWER,
    input  logic [width-1:0] CFG_UPPER,
    output logic             CFG_RDY,
    output logic             CFG_DONE,
    output logic             CFG_ERR,
    input  logic             HOLD,
    output logic [width-1:0] CNTR,
    output logic             CLK_OUT,
    output logic             PREEDGE,
    output logic [width-1:0] ACT_LOWER,
    output logic [width-1:0] ACT_UPPER
);

    state_t           state;
    logic             rdy_r;
    logic             done_r;
    logic             err_r;
    logic [width-1:0] act_lower_r;
    logic [width-1:0] act_upper_r;
    logic [width-1:0] pend_lower;
    logic [width-1:0] pend_upper;
    logic             req_ok;
    logic             capture;
    logic             wrap;
    logic             load_lower;

    assign req_ok     = cfg_valid(int'(CFG_LOWER), int'(CFG_UPPER), width);
    assign capture    = (state == IDLE) && CFG_EN && req_ok;
    assign load_lower = (state == PENDING);

    clock_div_core #(
        .width      (width),
        .init_upper (init_upper)
    ) u_core (
        .CLK        (CLK),
        .RST        (RST),
        .HOLD       (HOLD),
        .load_lower (load_lower),
        .pend_lower (pend_lower),
        .act_lower  (act_lower_r),
        .act_upper  (act_upper_r),
        .cntr       (CNTR),
        .wrap       (wrap),
        .clk_out    (CLK_OUT),
        .preedge    (PREEDGE)
    );

    // Pending bounds are plain data: only meaningful while PENDING, so no reset.
    always_ff @(posedge CLK) begin
        if (capture) begin
            pend_lower <= CFG_LOWER;
            pend_upper <= CFG_UPPER;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            rdy_r       <= 1'b1;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            act_lower_r <= width'(init_lower);
            act_upper_r <= width'(init_upper);
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (CFG_EN) begin
                        if (req_ok) begin
                            state <= PENDING;
                            rdy_r <= 1'b0;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                PENDING: begin
                    // The core reloads from pend_lower on this same edge.
                    if (wrap) begin
                        act_lower_r <= pend_lower;
                        act_upper_r <= pend_upper;
                        done_r      <= 1'b1;
                        state       <= APPLIED;
                    end
                end
                APPLIED: begin
                    state <= IDLE;
                    rdy_r <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    rdy_r <= 1'b1;
                end
            endcase
        end
    end

    assign CFG_RDY   = rdy_r;
    assign CFG_DONE  = done_r;
    assign CFG_ERR   = err_r;
    assign ACT_LOWER = act_lower_r;
    assign ACT_UPPER = act_upper_r;

endmodule
